// File: rtl/spi_cmd_parser.sv
// Framed SPI command decoder: SYNC, OP, LEN, 0..MAX_LEN payload bytes, XOR checksum.
// Optional SPI_CMD_ERRCNT_EN adds a saturating error counter cleared by an OP 8'hEC, LEN 0 frame.
module spi_cmd_parser #(
   parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
   parameter int unsigned MAX_LEN     = 2,
   parameter int unsigned TIMEOUT_CYC = 25000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        spi_cs,
   output logic        cmd_valid,
   output logic [7:0]  cmd_op,
   output logic [15:0] cmd_arg,
   output logic        err_valid,
   output logic [1:0]  err_code
`ifdef SPI_CMD_ERRCNT_EN
   ,
   output logic [7:0]  err_count
`endif
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {StIdle, StOp, StLen, StPay, StChk} state_e;

   state_e        state_q, state_d;
   logic [7:0]    op_q, op_d;
   logic [1:0]    len_q, len_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [7:0]    chk_q, chk_d;
   logic [15:0]   arg_q, arg_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic          err_valid_q, err_valid_d;
   logic [1:0]    err_code_q, err_code_d;
   logic [7:0]    cmd_op_q, cmd_op_d;
   logic [15:0]   cmd_arg_q, cmd_arg_d;
`ifdef SPI_CMD_ERRCNT_EN
   logic [7:0]    err_cnt_q, err_cnt_d;
`endif

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      chk_d       = chk_q;
      arg_d       = arg_q;
      cmd_valid_d = 1'b0;
      err_valid_d = 1'b0;
      err_code_d  = err_code_q;
      cmd_op_d    = cmd_op_q;
      cmd_arg_d   = cmd_arg_q;

      if (rx_valid) begin
         unique case (state_q)
            StIdle: begin
               if (rx_data == SYNC_BYTE) state_d = StOp;
            end
            StOp: begin
               op_d    = rx_data;
               chk_d   = rx_data;
               arg_d   = 16'h0000;
               cnt_d   = 2'd0;
               state_d = StLen;
            end
            StLen: begin
               if (rx_data > 8'(MAX_LEN)) begin
                  err_valid_d = 1'b1;
                  err_code_d  = 2'd1;
                  state_d     = StIdle;
               end else begin
                  len_d   = rx_data[1:0];
                  chk_d   = chk_q ^ rx_data;
                  state_d = (rx_data == 8'h00) ? StChk : StPay;
               end
            end
            StPay: begin
               arg_d = {arg_q[7:0], rx_data};
               chk_d = chk_q ^ rx_data;
               cnt_d = cnt_q + 2'd1;
               if ((cnt_q + 2'd1) == len_q) state_d = StChk;
            end
            StChk: begin
               if (rx_data == chk_q) begin
                  cmd_valid_d = 1'b1;
                  cmd_op_d    = op_q;
                  cmd_arg_d   = arg_q;
               end else begin
                  err_valid_d = 1'b1;
                  err_code_d  = 2'd0;
               end
               state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end

      // Byte is processed first; CS abort only if the frame is still open afterwards.
      if (!err_valid_d && spi_cs && (state_d != StIdle)) begin
         err_valid_d = 1'b1;
         err_code_d  = 2'd3;
         state_d     = StIdle;
      end else if (!rx_valid && (state_q != StIdle) && (timer_q == TW'(TIMEOUT_CYC - 1))) begin
         err_valid_d = 1'b1;
         err_code_d  = 2'd2;
         state_d     = StIdle;
      end

      timer_d = (rx_valid || (state_d == StIdle)) ? '0 : timer_q + 1'b1;
   end

`ifdef SPI_CMD_ERRCNT_EN
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_valid_d) begin
         if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else if (cmd_valid_d && (op_q == 8'hEC) && (len_q == 2'd0)) begin
         err_cnt_d = 8'h00;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_cnt_q <= 8'h00;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_count = err_cnt_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         op_q        <= 8'h00;
         len_q       <= 2'd0;
         cnt_q       <= 2'd0;
         chk_q       <= 8'h00;
         arg_q       <= 16'h0000;
         timer_q     <= '0;
         cmd_valid_q <= 1'b0;
         err_valid_q <= 1'b0;
         err_code_q  <= 2'd0;
         cmd_op_q    <= 8'h00;
         cmd_arg_q   <= 16'h0000;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         chk_q       <= chk_d;
         arg_q       <= arg_d;
         timer_q     <= timer_d;
         cmd_valid_q <= cmd_valid_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         cmd_op_q    <= cmd_op_d;
         cmd_arg_q   <= cmd_arg_d;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign cmd_op    = cmd_op_q;
   assign cmd_arg   = cmd_arg_q;

endmodule

// File: tb/tb_spi_cmd_parser.sv
// Randomized self-checking bench for spi_cmd_parser; expectations derive from frame construction.
// Define SPI_CMD_ERRCNT_EN to also check err_count.
module tb_spi_cmd_parser;

   localparam int unsigned TO = 25000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        spi_cs = 1'b0;
   logic        cmd_valid;
   logic [7:0]  cmd_op;
   logic [15:0] cmd_arg;
   logic        err_valid;
   logic [1:0]  err_code;
`ifdef SPI_CMD_ERRCNT_EN
   logic [7:0]  err_count;
`endif

   spi_cmd_parser #(
      .SYNC_BYTE  (8'hA5),
      .MAX_LEN    (2),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .spi_cs   (spi_cs),
      .cmd_valid(cmd_valid),
      .cmd_op   (cmd_op),
      .cmd_arg  (cmd_arg),
      .err_valid(err_valid),
      .err_code (err_code)
`ifdef SPI_CMD_ERRCNT_EN
      ,
      .err_count(err_count)
`endif
   );

   always #20 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_cmd   = 0;
   int          n_err   = 0;
   int          n_both  = 0;
   logic [1:0]  last_code = 2'd0;
   logic [7:0]  fq[$];
   logic [7:0]  exp_op = 8'h00;
   logic [15:0] exp_arg = 16'h0000;
   int          exp_ec = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmd_valid) n_cmd++;
      if (err_valid) begin
         n_err++;
         last_code = err_code;
      end
      if (cmd_valid && err_valid) n_both++;
   end

   // Append a frame; flip != 0 corrupts the checksum byte.
   function automatic void push_frame(input logic [7:0] op, input int len, input logic [7:0] p0,
                                      input logic [7:0] p1, input logic [7:0] flip,
                                      output logic [15:0] arg);
      logic [7:0] c;
      c = op ^ 8'(len);
      fq.push_back(8'hA5);
      fq.push_back(op);
      fq.push_back(8'(len));
      if (len >= 1) begin fq.push_back(p0); c = c ^ p0; end
      if (len == 2) begin fq.push_back(p1); c = c ^ p1; end
      fq.push_back(c ^ flip);
      arg = (len == 0) ? 16'h0000 : (len == 1) ? {8'h00, p0} : {p0, p1};
   endfunction

   function automatic void note_cmd(input logic [7:0] op, input int len, input logic [15:0] arg);
      exp_op  = op;
      exp_arg = arg;
      if (op == 8'hEC && len == 0) exp_ec = 0;
   endfunction

   task automatic send_bytes(input bit cs_at_last, input int gap_max);
      for (int i = 0; i < fq.size(); i++) begin
         rx_data  = fq[i];
         rx_valid = 1'b1;
         if (cs_at_last && i == fq.size() - 1) spi_cs = 1'b1;
         @(negedge clk);
         rx_valid = 1'b0;
         spi_cs   = 1'b0;
         if (i != fq.size() - 1) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      end
      fq.delete();
   endtask

   task automatic settle_and_check(input int exp_ncmd, input int exp_nerr, input logic [1:0] code);
      repeat (3) @(negedge clk);
      #1;
      check_val("cmd_count", n_cmd, exp_ncmd);
      check_val("err_count_pulses", n_err, exp_nerr);
      if (exp_nerr > 0) check_val("err_code", last_code, code);
      check_val("no_overlap", n_both, 0);
      check_val("cmd_op", cmd_op, exp_op);
      check_val("cmd_arg", cmd_arg, exp_arg);
`ifdef SPI_CMD_ERRCNT_EN
      check_val("err_count", err_count, exp_ec);
`endif
      n_cmd  = 0;
      n_err  = 0;
      n_both = 0;
   endtask

   task automatic run_frame(input int exp_ncmd, input int exp_nerr, input logic [1:0] code,
                            input bit cs_at_last, input bit cs_after, input int gap_max);
      @(negedge clk);
      send_bytes(cs_at_last, gap_max);
      check_val("lat_cmd", cmd_valid, (exp_ncmd > 0) ? 1 : 0);
      check_val("lat_err", err_valid, (exp_nerr > 0 && !cs_after) ? 1 : 0);
      if (cs_after) begin
         spi_cs = 1'b1;
         @(negedge clk);
         spi_cs = 1'b0;
         check_val("lat_cs_err", err_valid, 1);
      end
      if (exp_nerr > 0) exp_ec = (exp_ec + exp_nerr > 255) ? 255 : exp_ec + exp_nerr;
      settle_and_check(exp_ncmd, exp_nerr, code);
   endtask

   initial begin
      logic [15:0] a, a2;
      logic [7:0]  op, p0, p1, g;
      int          len, kind, k, cyc;

      #50;
      check_val("rst_cmd_valid", cmd_valid, 0);
      check_val("rst_err_valid", err_valid, 0);
      check_val("rst_cmd_op", cmd_op, 0);
      check_val("rst_cmd_arg", cmd_arg, 0);
      check_val("rst_err_code", err_code, 0);
      @(negedge clk);
      rst_n = 1'b1;

      push_frame(8'hA1, 0, 8'h00, 8'h00, 8'h00, a);
      note_cmd(8'hA1, 0, a);
      run_frame(1, 0, 2'd0, 1'b0, 1'b0, 1);
      check_val("arg_len0", cmd_arg, 16'h0000);

      push_frame(8'h10, 2, 8'h12, 8'h34, 8'h00, a);
      note_cmd(8'h10, 2, a);
      run_frame(1, 0, 2'd0, 1'b0, 1'b0, 1);
      check_val("arg_len2", cmd_arg, 16'h1234);
      push_frame(8'h20, 1, 8'h7F, 8'h00, 8'h00, a);
      note_cmd(8'h20, 1, a);
      run_frame(1, 0, 2'd0, 1'b0, 1'b0, 1);
      check_val("arg_len1", cmd_arg, 16'h007F);

      // Bad checksum, then over-long LEN
      fq = '{8'hA5, 8'hA1, 8'h00, 8'hA0};
      run_frame(0, 1, 2'd0, 1'b0, 1'b0, 1);
      fq = '{8'hA5, 8'h10, 8'h03};
      run_frame(0, 1, 2'd1, 1'b0, 1'b0, 1);

      // Inter-byte timeout
      @(negedge clk);
      fq = '{8'hA5, 8'hA1};
      send_bytes(1'b0, 0);
      cyc = 0;
      for (int i = 1; i <= TO + 50; i++) begin
         @(negedge clk);
         if (err_valid) begin
            cyc = i;
            break;
         end
      end
      check_val("timeout_seen", (cyc >= TO - 1 && cyc <= TO + 2) ? 1 : 0, 1);
      exp_ec = (exp_ec == 255) ? 255 : exp_ec + 1;
      settle_and_check(0, 1, 2'd2);
      push_frame(8'hA1, 0, 8'h00, 8'h00, 8'h00, a);
      note_cmd(8'hA1, 0, a);
      run_frame(1, 0, 2'd0, 1'b0, 1'b0, 2);

      // CS abort mid-payload, then leading garbage
      fq = '{8'hA5, 8'h10, 8'h02, 8'h12};
      run_frame(0, 1, 2'd3, 1'b0, 1'b1, 1);
      fq = '{8'h00, 8'hFF};
      push_frame(8'hA1, 0, 8'h00, 8'h00, 8'h00, a);
      note_cmd(8'hA1, 0, a);
      run_frame(1, 0, 2'd0, 1'b0, 1'b0, 1);

      // CS rising together with the closing byte: byte wins
      push_frame(8'h33, 1, 8'h44, 8'h00, 8'h00, a);
      note_cmd(8'h33, 1, a);
      run_frame(1, 0, 2'd0, 1'b1, 1'b0, 1);
      fq = '{8'hA5, 8'h10, 8'h05};
      run_frame(0, 1, 2'd1, 1'b1, 1'b0, 1);
      push_frame(8'h55, 0, 8'h00, 8'h00, 8'h01, a);
      run_frame(0, 1, 2'd0, 1'b1, 1'b0, 1);
      fq = '{8'hA5, 8'h10};
      run_frame(0, 1, 2'd3, 1'b1, 1'b0, 1);

      // SYNC value as data, back-to-back frames with no idle cycle
      push_frame(8'hA5, 2, 8'hA5, 8'hA5, 8'h00, a);
      push_frame(8'h42, 1, 8'h99, 8'h00, 8'h00, a2);
      note_cmd(8'hA5, 2, a);
      note_cmd(8'h42, 1, a2);
      run_frame(2, 0, 2'd0, 1'b0, 1'b0, 0);

      for (int it = 0; it < 150; it++) begin
         kind = $urandom_range(5, 0);
         op   = 8'($urandom);
         len  = $urandom_range(2, 0);
         p0   = 8'($urandom);
         p1   = 8'($urandom);
         case (kind)
            0: begin
               push_frame(op, len, p0, p1, 8'h00, a);
               note_cmd(op, len, a);
               run_frame(1, 0, 2'd0, 1'b0, 1'b0, 2);
            end
            1: begin
               push_frame(op, len, p0, p1, 8'($urandom_range(255, 1)), a);
               run_frame(0, 1, 2'd0, 1'b0, 1'b0, 2);
            end
            2: begin
               fq = '{8'hA5, op, 8'($urandom_range(255, 3))};
               run_frame(0, 1, 2'd1, 1'b0, 1'b0, 2);
            end
            3: begin
               for (int j = 0; j < $urandom_range(3, 1); j++) begin
                  g = 8'($urandom);
                  if (g == 8'hA5) g = 8'h5A;
                  fq.push_back(g);
               end
               push_frame(op, len, p0, p1, 8'h00, a);
               note_cmd(op, len, a);
               run_frame(1, 0, 2'd0, 1'b0, 1'b0, 2);
            end
            4: begin
               push_frame(op, len, p0, p1, 8'h00, a);
               k = $urandom_range(len + 3, 1);
               while (fq.size() > k) void'(fq.pop_back());
               run_frame(0, 1, 2'd3, 1'b0, 1'b1, 2);
            end
            default: begin
               push_frame(8'hA5, len, 8'hA5, p1, 8'h00, a);
               note_cmd(8'hA5, len, a);
               run_frame(1, 0, 2'd0, 1'b0, 1'b0, 2);
            end
         endcase
      end

      // Three errors, then the counter-clear frame
      fq = '{8'hA5, 8'h01, 8'h07};
      run_frame(0, 1, 2'd1, 1'b0, 1'b0, 1);
      fq = '{8'hA5, 8'h01, 8'h08};
      run_frame(0, 1, 2'd1, 1'b0, 1'b0, 1);
      fq = '{8'hA5, 8'h01, 8'h00, 8'h00};
      run_frame(0, 1, 2'd0, 1'b0, 1'b0, 1);
      push_frame(8'hEC, 0, 8'h00, 8'h00, 8'h00, a);
      note_cmd(8'hEC, 0, a);
      run_frame(1, 0, 2'd0, 1'b0, 1'b0, 1);

      // Reset mid-frame
      @(negedge clk);
      fq = '{8'hA5, 8'h10};
      send_bytes(1'b0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_cmd_op", cmd_op, 0);
      check_val("mid_rst_cmd_arg", cmd_arg, 0);
      check_val("mid_rst_err_code", err_code, 0);
      check_val("mid_rst_valids", {cmd_valid, err_valid}, 0);
      exp_op  = 8'h00;
      exp_arg = 16'h0000;
      exp_ec  = 0;
`ifdef SPI_CMD_ERRCNT_EN
      check_val("mid_rst_err_count", err_count, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      n_cmd  = 0;
      n_err  = 0;
      n_both = 0;
      push_frame(8'hA1, 0, 8'h00, 8'h00, 8'h00, a);
      note_cmd(8'hA1, 0, a);
      run_frame(1, 0, 2'd0, 1'b0, 1'b0, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
